// File: rtl/alu_bist_pkg.sv
// Shared types and constants for the ALU built-in self-test engine.
package alu_bist_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int NUM_VECTORS = 2048;
  localparam int VEC_W       = 11;
  localparam int MISR_W      = 16;
  localparam int ZERR_W      = 12;

  // Shift left, fold the dropped MSB back through the polynomial, then mix in data.
  function automatic logic [MISR_W-1:0] misr_next(input logic [MISR_W-1:0] sig,
                                                  input logic [MISR_W-1:0] poly,
                                                  input logic [MISR_W-1:0] d);
    return {sig[MISR_W-2:0], 1'b0} ^ (sig[MISR_W-1] ? poly : '0) ^ d;
  endfunction

endpackage

// File: rtl/misr16.sv
// 16-bit multiple-input signature register; init reloads the seed, en folds in one data word.
module misr16
  import alu_bist_pkg::*;
#(
  parameter logic [MISR_W-1:0] SEED = 16'hFFFF,
  parameter logic [MISR_W-1:0] POLY = 16'h1021
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              init,
  input  logic              en,
  input  logic [MISR_W-1:0] d,
  output logic [MISR_W-1:0] sig
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sig <= SEED;
    end else if (init) begin
      sig <= SEED;
    end else if (en) begin
      sig <= misr_next(sig, POLY, d);
    end
  end

endmodule

// File: rtl/alu_bist.sv
// Self-test engine that sweeps all 2048 ALU vectors, compresses the responses into a
// MISR signature and counts zero-flag inconsistencies.
module alu_bist
  import alu_bist_pkg::*;
#(
  parameter logic [MISR_W-1:0] SEED       = 16'hFFFF,
  parameter logic [MISR_W-1:0] POLY       = 16'h1021,
  parameter logic [MISR_W-1:0] GOLDEN_SIG = 16'h0000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  output logic [3:0]        alu_A,
  output logic [3:0]        alu_B,
  output logic [1:0]        alu_Op,
  output logic              alu_arit,
  input  logic [3:0]        alu_R,
  input  logic              alu_z,
  input  logic              alu_c,
  input  logic              alu_s,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [MISR_W-1:0] signature,
  output logic [ZERR_W-1:0] zerr_count,
  output state_t            state_dbg
);

  // Handshake: start is a one-cycle request, accepted only in IDLE or DONE and only
  // when abort is low; done is a level held until the next accepted start or abort.

  state_t             state;
  logic [VEC_W-1:0]   vec;
  logic               start_ok;
  logic               capture;
  logic               z_err;
  logic [MISR_W-1:0]  misr_d;

  assign {alu_arit, alu_Op, alu_A, alu_B} = vec;
  assign state_dbg = state;

  assign start_ok = start && !abort && (state != RUN);
  assign capture  = !abort && (state == RUN);
  assign z_err    = (alu_z != ~|alu_R);

  // Logic-group carry and sign carry no meaning, so they never reach the signature.
  assign misr_d = {9'b0, alu_c & alu_arit, alu_s & alu_arit, alu_z, alu_R};

  misr16 #(
    .SEED (SEED),
    .POLY (POLY)
  ) u_misr (
    .clk     (clk),
    .reset_n (reset_n),
    .init    (start_ok),
    .en      (capture),
    .d       (misr_d),
    .sig     (signature)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      vec        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      zerr_count <= '0;
    end else if (abort) begin
      state <= IDLE;
      vec   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state      <= RUN;
            vec        <= '0;
            busy       <= 1'b1;
            done       <= 1'b0;
            zerr_count <= '0;
          end
        end
        RUN: begin
          vec <= vec + 1'b1;
          if (z_err && (zerr_count != '1)) begin
            zerr_count <= zerr_count + 1'b1;
          end
          if (vec == VEC_W'(NUM_VECTORS - 1)) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          vec   <= '0;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  // Signature and error count are frozen while done is high, so this is stable.
  assign pass = done && (signature == GOLDEN_SIG) && (zerr_count == '0);

endmodule

// File: tb/tb_alu_bist.sv
// Directed bench for alu_bist with a behavioural 4-bit ALU that can inject faults.
module tb_alu_bist;
  import alu_bist_pkg::*;

  // ALU reference: logic group AND/OR/XOR/NOT A, arithmetic group A+B/A-B/A+1/A-1.
  // Modes: 0 good, 1 R[0] stuck at 0, 2 z inverted at vector 0, 3 random logic c/s.
  function automatic logic [6:0] alu_resp(input logic [10:0] v, input int mode,
                                          input logic [1:0] rnd);
    logic [3:0] a, b, r;
    logic [1:0] op;
    logic       arit, c, s, z;
    logic [4:0] w;
    a = v[7:4]; b = v[3:0]; op = v[9:8]; arit = v[10];
    c = 1'b0; s = 1'b0; w = '0; r = '0;
    if (arit) begin
      case (op)
        2'd0:    w = {1'b0, a} + {1'b0, b};
        2'd1:    w = {1'b0, a} - {1'b0, b};
        2'd2:    w = {1'b0, a} + 5'd1;
        default: w = {1'b0, a} - 5'd1;
      endcase
      r = w[3:0]; c = w[4]; s = r[3];
    end else begin
      case (op)
        2'd0:    r = a & b;
        2'd1:    r = a | b;
        2'd2:    r = a ^ b;
        default: r = ~a;
      endcase
      if (mode == 3) begin
        c = rnd[1]; s = rnd[0];
      end
    end
    if (mode == 1) r[0] = 1'b0;
    z = (r == 4'h0);
    if (mode == 2 && v == 11'd0) z = ~z;
    return {c, s, z, r};
  endfunction

  function automatic logic [6:0] model_d(input logic [10:0] v, input int mode);
    logic [6:0] r;
    r = alu_resp(v, mode, 2'b00);
    r[6] = r[6] & v[10];
    r[5] = r[5] & v[10];
    return r;
  endfunction

  function automatic logic [15:0] misr_step(input logic [15:0] s, input logic [6:0] d);
    logic [15:0] n;
    n = {s[14:0], 1'b0};
    if (s[15]) n = n ^ 16'h1021;
    return n ^ {9'b0, d};
  endfunction

  function automatic logic [15:0] golden_sig();
    logic [15:0] sg;
    logic [10:0] v;
    sg = 16'hFFFF;
    for (int hi = 0; hi < 8; hi++)
      for (int a = 0; a < 16; a++)
        for (int b = 0; b < 16; b++) begin
          v = {hi[2:0], a[3:0], b[3:0]};
          sg = misr_step(sg, model_d(v, 0));
        end
    return sg;
  endfunction

  localparam logic [15:0] GOLDEN = golden_sig();

  logic        clk;
  logic        reset_n;
  logic        start;
  logic        abort;
  logic [3:0]  alu_A, alu_B, alu_R;
  logic [1:0]  alu_Op;
  logic        alu_arit, alu_z, alu_c, alu_s;
  logic        busy, done, pass;
  logic [15:0] signature;
  logic [11:0] zerr_count;
  state_t      state_dbg;

  int          fault_mode;
  logic [1:0]  rnd_cs;
  logic [6:0]  resp;
  logic [10:0] exp_q[$];
  int          n_checks;
  int          n_fail;

  alu_bist #(
    .SEED       (16'hFFFF),
    .POLY       (16'h1021),
    .GOLDEN_SIG (GOLDEN)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .abort      (abort),
    .alu_A      (alu_A),
    .alu_B      (alu_B),
    .alu_Op     (alu_Op),
    .alu_arit   (alu_arit),
    .alu_R      (alu_R),
    .alu_z      (alu_z),
    .alu_c      (alu_c),
    .alu_s      (alu_s),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .signature  (signature),
    .zerr_count (zerr_count),
    .state_dbg  (state_dbg)
  );

  always_comb resp = alu_resp({alu_arit, alu_Op, alu_A, alu_B}, fault_mode, rnd_cs);
  assign {alu_c, alu_s, alu_z, alu_R} = resp;

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse start, then follow the sweep one negedge at a time until busy drops.
  task automatic run_sweep(input int mode, input int restart_at,
                           output int busy_cycles, output int port_errs,
                           output logic [15:0] msig, output int mzerr,
                           output logic k3ff_ok, output logic k400_ok);
    logic [10:0] exp_v;
    logic [6:0]  r;
    int          k;
    fault_mode = mode;
    exp_q.delete();
    for (int i = 0; i < NUM_VECTORS; i++) exp_q.push_back(11'(i));
    msig = 16'hFFFF; mzerr = 0; busy_cycles = 0; port_errs = 0;
    k3ff_ok = 1'b0; k400_ok = 1'b0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    k = 0;
    while (busy === 1'b1 && k < 2100) begin
      start = (k == restart_at);
      if (mode == 3) rnd_cs = 2'($urandom_range(0, 3));
      if (exp_q.size() > 0) begin
        exp_v = exp_q.pop_front();
        if ({alu_arit, alu_Op, alu_A, alu_B} !== exp_v) port_errs++;
      end else begin
        port_errs++;
      end
      if (k == 'h3FF)
        k3ff_ok = (alu_arit === 1'b0 && alu_Op === 2'b11 && alu_A === 4'hF && alu_B === 4'hF);
      if (k == 'h400)
        k400_ok = (alu_arit === 1'b1 && alu_Op === 2'b00 && alu_A === 4'h0 && alu_B === 4'h0);
      r = alu_resp(11'(k), mode, 2'b00);
      if (r[4] != (r[3:0] == 4'h0)) mzerr++;
      msig = misr_step(msig, model_d(11'(k), mode));
      busy_cycles++;
      k++;
      @(negedge clk);
    end
    start = 1'b0;
    rnd_cs = 2'b00;
  endtask

  task automatic test_reset();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
    n_checks++; if (pass !== 1'b0) begin n_fail++; $display("FAIL reset_pass got %b want 0", pass); end
    n_checks++; if (signature !== 16'hFFFF) begin n_fail++; $display("FAIL reset_sig got %h want ffff", signature); end
    n_checks++; if (zerr_count !== 12'h0) begin n_fail++; $display("FAIL reset_zerr got %h want 0", zerr_count); end
    n_checks++; if ({alu_arit, alu_Op, alu_A, alu_B} !== 11'h0) begin n_fail++;
      $display("FAIL reset_ports got %h want 0", {alu_arit, alu_Op, alu_A, alu_B}); end
    n_checks++; if (state_dbg !== IDLE) begin n_fail++; $display("FAIL reset_state got %0d want 0", state_dbg); end
  endtask

  task automatic test_fault_free();
    int bc, pe, mz; logic [15:0] ms; logic k3, k4;
    run_sweep(0, -1, bc, pe, ms, mz, k3, k4);
    n_checks++; if (bc != 2048) begin n_fail++; $display("FAIL good_busy_cycles got %0d want 2048", bc); end
    n_checks++; if (pe != 0) begin n_fail++; $display("FAIL good_port_seq got %0d errors want 0", pe); end
    n_checks++; if (k3 !== 1'b1) begin n_fail++; $display("FAIL good_vec_3ff got %b want 1", k3); end
    n_checks++; if (k4 !== 1'b1) begin n_fail++; $display("FAIL good_vec_400 got %b want 1", k4); end
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL good_done got %b want 1", done); end
    n_checks++; if (pass !== 1'b1) begin n_fail++; $display("FAIL good_pass got %b want 1", pass); end
    n_checks++; if (zerr_count !== 12'h0) begin n_fail++; $display("FAIL good_zerr got %h want 0", zerr_count); end
    n_checks++; if (signature !== ms) begin n_fail++; $display("FAIL good_sig got %h want %h", signature, ms); end
    n_checks++; if (signature !== GOLDEN) begin n_fail++; $display("FAIL good_golden got %h want %h", signature, GOLDEN); end
    n_checks++; if ({alu_arit, alu_Op, alu_A, alu_B} !== 11'h0) begin n_fail++;
      $display("FAIL done_ports got %h want 0", {alu_arit, alu_Op, alu_A, alu_B}); end
    repeat (5) @(negedge clk);
    n_checks++; if (done !== 1'b1 || signature !== ms || pass !== 1'b1) begin n_fail++;
      $display("FAIL done_hold got done=%b sig=%h pass=%b want 1 %h 1", done, signature, pass, ms); end
  endtask

  task automatic test_stuck_r0();
    int bc, pe, mz; logic [15:0] ms; logic k3, k4;
    run_sweep(1, -1, bc, pe, ms, mz, k3, k4);
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL stuck_done got %b want 1", done); end
    n_checks++; if (pass !== 1'b0) begin n_fail++; $display("FAIL stuck_pass got %b want 0", pass); end
    n_checks++; if (signature !== ms) begin n_fail++; $display("FAIL stuck_sig got %h want %h", signature, ms); end
    n_checks++; if (signature === GOLDEN) begin n_fail++; $display("FAIL stuck_sig_differs got %h want not %h", signature, GOLDEN); end
  endtask

  task automatic test_z_fault();
    int bc, pe, mz; logic [15:0] ms; logic k3, k4;
    run_sweep(2, -1, bc, pe, ms, mz, k3, k4);
    n_checks++; if (zerr_count !== 12'd1) begin n_fail++; $display("FAIL zflt_zerr got %0d want 1", zerr_count); end
    n_checks++; if (pass !== 1'b0) begin n_fail++; $display("FAIL zflt_pass got %b want 0", pass); end
    n_checks++; if (signature !== ms) begin n_fail++; $display("FAIL zflt_sig got %h want %h", signature, ms); end
  endtask

  task automatic test_logic_cs_random();
    int bc, pe, mz; logic [15:0] ms; logic k3, k4;
    run_sweep(3, -1, bc, pe, ms, mz, k3, k4);
    n_checks++; if (signature !== GOLDEN) begin n_fail++; $display("FAIL cs_mask_sig got %h want %h", signature, GOLDEN); end
    n_checks++; if (pass !== 1'b1) begin n_fail++; $display("FAIL cs_mask_pass got %b want 1", pass); end
  endtask

  task automatic test_abort();
    int bc, pe, mz; logic [15:0] ms; logic k3, k4;
    fault_mode = 0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    ms = 16'hFFFF;
    for (int k = 0; k < 100; k++) begin
      ms = misr_step(ms, model_d(11'(k), 0));
      @(negedge clk);
    end
    abort = 1'b1;
    @(negedge clk) abort = 1'b0;
    n_checks++; if (busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0) begin n_fail++;
      $display("FAIL abort_flags got busy=%b done=%b pass=%b want 0 0 0", busy, done, pass); end
    n_checks++; if ({alu_arit, alu_Op, alu_A, alu_B} !== 11'h0) begin n_fail++;
      $display("FAIL abort_ports got %h want 0", {alu_arit, alu_Op, alu_A, alu_B}); end
    n_checks++; if (signature !== ms) begin n_fail++; $display("FAIL abort_sig_kept got %h want %h", signature, ms); end
    n_checks++; if (state_dbg !== IDLE) begin n_fail++; $display("FAIL abort_state got %0d want 0", state_dbg); end
    start = 1'b1; abort = 1'b1;
    @(negedge clk) begin start = 1'b0; abort = 1'b0; end
    n_checks++; if (busy !== 1'b0 || state_dbg !== IDLE) begin n_fail++;
      $display("FAIL abort_beats_start got busy=%b state=%0d want 0 0", busy, state_dbg); end
    run_sweep(0, -1, bc, pe, ms, mz, k3, k4);
    n_checks++; if (bc != 2048 || pass !== 1'b1) begin n_fail++;
      $display("FAIL abort_rerun got cycles=%0d pass=%b want 2048 1", bc, pass); end
  endtask

  task automatic test_async_reset();
    int bc, pe, mz; logic [15:0] ms; logic k3, k4;
    fault_mode = 0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (500) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    n_checks++; if (busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0 || zerr_count !== 12'h0) begin n_fail++;
      $display("FAIL areset_flags got busy=%b done=%b pass=%b zerr=%h want 0 0 0 0", busy, done, pass, zerr_count); end
    n_checks++; if (signature !== 16'hFFFF) begin n_fail++; $display("FAIL areset_sig got %h want ffff", signature); end
    n_checks++; if ({alu_arit, alu_Op, alu_A, alu_B} !== 11'h0) begin n_fail++;
      $display("FAIL areset_ports got %h want 0", {alu_arit, alu_Op, alu_A, alu_B}); end
    @(negedge clk) reset_n = 1'b1;
    run_sweep(0, -1, bc, pe, ms, mz, k3, k4);
    n_checks++; if (bc != 2048 || pass !== 1'b1) begin n_fail++;
      $display("FAIL areset_rerun got cycles=%0d pass=%b want 2048 1", bc, pass); end
  endtask

  task automatic test_back_to_back();
    int bc, pe, mz; logic [15:0] ms; logic k3, k4;
    // Begins in DONE; a start mid-sweep must be ignored.
    run_sweep(0, 37, bc, pe, ms, mz, k3, k4);
    n_checks++; if (pe != 0) begin n_fail++; $display("FAIL b2b_port_seq got %0d errors want 0", pe); end
    n_checks++; if (bc != 2048) begin n_fail++; $display("FAIL b2b_busy_cycles got %0d want 2048", bc); end
    n_checks++; if (pass !== 1'b1 || signature !== GOLDEN) begin n_fail++;
      $display("FAIL b2b_result got pass=%b sig=%h want 1 %h", pass, signature, GOLDEN); end
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    fault_mode = 0; rnd_cs = 2'b00;
    reset_n = 1'b0; start = 1'b0; abort = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_fault_free();
    test_stuck_r0();
    test_z_fault();
    test_logic_cs_random();
    test_abort();
    test_async_reset();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_bist.md
Name: alu_bist

Overview:
Hardware built-in self-test engine that drives the 4-bit ALU from the initiator side. It sweeps every operand/operation combination (2048 vectors) onto the ALU inputs and compresses each returned result and flag set into a 16-bit MISR signature. It also counts zero-flag inconsistencies and reports pass/fail against a golden signature. It sits beside the ALU in the datapath and is selected in place of the normal operand sources during test.

Parameters:
SEED, 16'hFFFF, MISR initial value loaded on start.
POLY, 16'h1021, MISR feedback polynomial (x^16+x^12+x^5+1).
GOLDEN_SIG, 16'h0000, expected final signature for a fault-free ALU; set per build from the bench model.

Ports:
clk  input  1  system clock, rising edge.
reset_n  input  1  asynchronous active-low reset.
start  input  1  one-cycle request to begin a sweep; honoured in IDLE or DONE only.
abort  input  1  synchronous abort; returns to IDLE from any state.
alu_A  output  4  operand A to the ALU, registered.
alu_B  output  4  operand B to the ALU, registered.
alu_Op  output  2  operation select to the ALU, registered.
alu_arit  output  1  0 = logic group, 1 = arithmetic group, registered.
alu_R  input  4  ALU result, combinational from the driven vector.
alu_z  input  1  ALU zero flag.
alu_c  input  1  ALU carry flag; meaningful only when alu_arit=1.
alu_s  input  1  ALU sign flag; meaningful only when alu_arit=1.
busy  output  1  high while in RUN.
done  output  1  high in DONE, held until the next start or abort.
pass  output  1  valid when done: (signature==GOLDEN_SIG) && (zerr_count==0); 0 otherwise.
signature  output  16  current MISR value.
zerr_count  output  12  count of vectors where alu_z != ~|alu_R; saturates at 12'hFFF.

Behaviour:
- Reset (async, reset_n=0): state IDLE; alu_A, alu_B, alu_Op and alu_arit = 0; busy=0, done=0, pass=0; signature=SEED; zerr_count=0; vector counter=0.
- States: IDLE, RUN, DONE.
  - IDLE -> RUN on start.
  - RUN -> DONE after the capture of vector 2047.
  - DONE -> RUN on start.
  - Any state -> IDLE on abort. Abort has priority over start and over capture.
- Vector counter: 11 bits, {arit, Op[1:0], A[3:0], B[3:0]} = {alu_arit, alu_Op, alu_A, alu_B}. B is innermost and arit is outermost. The counter drives the ALU ports directly from registers.
- On the start edge:
  - counter=0, signature=SEED, zerr_count=0, done=0.
  - Vector 0 is driven during the first RUN cycle.
- Each RUN clock edge:
  - Capture the response to the currently driven vector into the MISR and the zero check.
  - Then increment the counter.
  - One vector per cycle; RUN lasts exactly 2048 cycles; done rises on edge 2048 after the start edge.
- MISR data word: d = {9'b0, c_m, s_m, alu_z, alu_R}, with c_m = alu_c & alu_arit and s_m = alu_s & alu_arit. Logic-group carry and sign are don't-care and are masked to 0.
- MISR update: next = {sig[14:0],1'b0} ^ (sig[15] ? POLY : 16'h0) ^ d.
- Zero check: each RUN edge, if alu_z != ~|alu_R, increment zerr_count (saturating).
- DONE:
  - Counter wraps to 0, so ALU ports return to 0.
  - signature, zerr_count and pass are frozen.
- Abort:
  - Ports, counter and done go to 0.
  - signature and zerr_count keep their last values; pass=0.
- Start while busy is ignored. Start and abort in the same cycle: abort wins.

Decomposition:
- Package alu_bist_pkg holds:
  - state encoding constants IDLE=2'd0, RUN=2'd1, DONE=2'd2;
  - NUM_VECTORS=2048;
  - MISR width 16.
- One sub-module, misr16: input clk, reset_n, init, en, d[15:0]; output sig[15:0]; parameters SEED and POLY.
- Counter, FSM and zero checker stay in alu_bist.

Test Plan:
- Fault-free ALU model, GOLDEN_SIG = bench-computed signature, start pulse:
  - busy high for exactly 2048 cycles; done=1 on the following cycle;
  - pass=1, zerr_count=0;
  - on RUN cycle k the ports equal k, e.g. k=0x3FF -> arit=0, Op=11, A=F, B=F; k=0x400 -> arit=1, Op=00, A=0, B=0.
- ALU model with R[0] stuck at 0, same GOLDEN_SIG -> done=1, pass=0, signature != GOLDEN_SIG.
- ALU model whose z is inverted only at arit=0, Op=00, A=0, B=0 -> zerr_count=1, pass=0.
- Logic-group c/s driven randomly with an otherwise correct model -> signature identical to the fault-free run, pass=1.
- Abort asserted on RUN cycle 100 -> next cycle busy=0, done=0, all ALU ports 0, pass=0; a new start then completes with pass=1.
- reset_n pulsed low mid-RUN (cycle 500), asynchronously -> outputs immediately at reset values, signature=16'hFFFF. Start after release -> full 2048-cycle run, pass=1. Start during DONE -> restart from vector 0.
